// File: rtl/gba_irq_pkg.sv
// gba_irq_pkg: shared IRQ source indices, MMIO write slots, halt FSM states and helpers.
package gba_irq_pkg;

    typedef enum int {
        IRQ_VBLANK = 0,
        IRQ_HBLANK,
        IRQ_VCOUNT,
        IRQ_TIMER0,
        IRQ_TIMER1,
        IRQ_TIMER2,
        IRQ_TIMER3,
        IRQ_SERIAL,
        IRQ_DMA0,
        IRQ_DMA1,
        IRQ_DMA2,
        IRQ_DMA3,
        IRQ_KEYPAD,
        IRQ_GAMEPAK
    } irq_src_e;

    localparam logic [1:0] IDX_IE_IF   = 2'd0;
    localparam logic [1:0] IDX_IME     = 2'd1;
    localparam logic [1:0] IDX_HALTCNT = 2'd2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HALT_REQ = 2'd1,
        HALTED   = 2'd2
    } halt_state_e;

    localparam logic [3:0] IRQ_NONE_ID = 4'hF;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] id;
        id = IRQ_NONE_ID;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) id = 4'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_edge_det.sv
// irq_edge_det: per-bit rising-edge detector so a held request level fires only once.
module irq_edge_det
    import gba_irq_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev;

    assign rise = d & ~prev;

    // remember last cycle's request levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= '0;
        else     prev <= d;
    end

endmodule

// File: rtl/gba_irq_ctrl.sv
// gba_irq_ctrl: GBA interrupt controller (IE/IF/IME, registered IRQ, HALTCNT halt/wake).
// Optional macro GBA_IRQ_PRIO_ENC_EN adds irq_id, the lowest enabled pending source.
module gba_irq_ctrl
    import gba_irq_pkg::*;
#(
    parameter int NUM_SRC = 14
) (
    input  logic               clock_16,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               reg_wr_en,
    input  logic [1:0]         reg_wr_idx,
    input  logic [31:0]        reg_wr_data,
    input  logic [3:0]         reg_wr_be,
    input  logic               cpu_ack_halt,
    output logic [15:0]        IE,
    output logic [15:0]        IF,
    output logic               IME,
    output logic               cpu_irq,
    output logic               cpu_halt
`ifdef GBA_IRQ_PRIO_ENC_EN
    ,
    output logic [3:0]         irq_id
`endif
);

    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

    logic [NUM_SRC-1:0] rise;
    logic [15:0]        rise_w, clr, if_next, ie_next, active;
    logic               wr_ie_if, ime_next, halt_wr, pending;
    halt_state_e        state, state_next;

    irq_edge_det #(.W(NUM_SRC)) u_edge (
        .clk  (clock_16),
        .rst  (reset),
        .d    (irq_src),
        .rise (rise)
    );

    assign wr_ie_if = reg_wr_en && reg_wr_idx == IDX_IE_IF;
    assign rise_w   = 16'(rise);
    assign clr      = {reg_wr_data[31:24] & {8{wr_ie_if && reg_wr_be[3]}},
                       reg_wr_data[23:16] & {8{wr_ie_if && reg_wr_be[2]}}};
    // a new edge overrides a same-cycle clear of that bit
    assign if_next  = ((IF & ~clr) | rise_w) & SRC_MASK;
    assign ie_next  = {wr_ie_if && reg_wr_be[1] ? reg_wr_data[15:8] : IE[15:8],
                       wr_ie_if && reg_wr_be[0] ? reg_wr_data[7:0]  : IE[7:0]} & SRC_MASK;
    assign ime_next = reg_wr_en && reg_wr_idx == IDX_IME && reg_wr_be[0] ? reg_wr_data[0] : IME;
    assign active   = IE & IF;
    assign pending  = |active;
    // HALTCNT byte 1 with bit 15 clear requests halt; bit 15 set (STOP) is not supported
    assign halt_wr  = reg_wr_en && reg_wr_idx == IDX_HALTCNT && reg_wr_be[1] && !reg_wr_data[15];

    // halt FSM next state: wake on pending regardless of IME, and wake beats ack
    always_comb begin
        state_next = state;
        if (state != RUN && pending)                state_next = RUN;
        else if (state == RUN && halt_wr && !pending) state_next = HALT_REQ;
        else if (state == HALT_REQ && cpu_ack_halt)   state_next = HALTED;
    end

    // register state, flags and outputs to the core
    always_ff @(posedge clock_16 or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            IE       <= '0;
            IF       <= '0;
            IME      <= 1'b0;
            cpu_irq  <= 1'b0;
            cpu_halt <= 1'b0;
        end else begin
            state    <= state_next;
            IE       <= ie_next;
            IF       <= if_next;
            IME      <= ime_next;
            cpu_irq  <= IME & pending;
            cpu_halt <= state_next != RUN;
        end
    end

`ifdef GBA_IRQ_PRIO_ENC_EN
    // lowest-numbered enabled pending source, aligned with cpu_irq
    always_ff @(posedge clock_16 or posedge reset) begin
        if (reset) irq_id <= IRQ_NONE_ID;
        else       irq_id <= lowest_set(active);
    end
`endif

endmodule

// File: tb/tb_gba_irq_ctrl.sv
// tb_gba_irq_ctrl: directed table, corner sequences and randomized model check for gba_irq_ctrl.
module tb_gba_irq_ctrl;

    localparam int N = 14;

    logic          clock_16 = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_src;
    logic          reg_wr_en;
    logic [1:0]    reg_wr_idx;
    logic [31:0]   reg_wr_data;
    logic [3:0]    reg_wr_be;
    logic          cpu_ack_halt;
    logic [15:0]   IE, IF;
    logic          IME, cpu_irq, cpu_halt;
`ifdef GBA_IRQ_PRIO_ENC_EN
    logic [3:0]    irq_id;
`endif

    int checks = 0;
    int failures = 0;

    gba_irq_ctrl #(.NUM_SRC(N)) dut (
        .clock_16     (clock_16),
        .reset        (reset),
        .irq_src      (irq_src),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_idx   (reg_wr_idx),
        .reg_wr_data  (reg_wr_data),
        .reg_wr_be    (reg_wr_be),
        .cpu_ack_halt (cpu_ack_halt),
        .IE           (IE),
        .IF           (IF),
        .IME          (IME),
        .cpu_irq      (cpu_irq),
        .cpu_halt     (cpu_halt)
`ifdef GBA_IRQ_PRIO_ENC_EN
        ,
        .irq_id       (irq_id)
`endif
    );

    always #5 clock_16 = ~clock_16;

    typedef struct {
        logic        wr;
        logic [1:0]  idx;
        logic [31:0] data;
        logic [3:0]  be;
        logic [N-1:0] src;
        logic        ack;
        logic [15:0] e_ie;
        logic [15:0] e_if;
        logic        e_ime;
        logic        e_irq;
        logic        e_halt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic wr, logic [1:0] idx, logic [31:0] data, logic [3:0] be,
                                logic [N-1:0] src, logic ack, logic [15:0] e_ie, logic [15:0] e_if,
                                logic e_ime, logic e_irq, logic e_halt);
        vec_t v;
        v.wr = wr; v.idx = idx; v.data = data; v.be = be; v.src = src; v.ack = ack;
        v.e_ie = e_ie; v.e_if = e_if; v.e_ime = e_ime; v.e_irq = e_irq; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_16);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [1:0] idx, input logic [31:0] data,
                         input logic [3:0] be, input logic [N-1:0] src, input logic ack);
        reg_wr_en = wr; reg_wr_idx = idx; reg_wr_data = data; reg_wr_be = be;
        irq_src = src; cpu_ack_halt = ack;
    endtask

    // reference model: architectural register view plus halt phase (0 run, 1 requested, 2 halted)
    logic [15:0]  m_ie, m_if;
    logic         m_ime, m_irq, m_halt;
    logic [N-1:0] m_prev;
    logic [3:0]   m_id;
    int           m_phase;

    task automatic model_reset();
        m_ie = 0; m_if = 0; m_ime = 0; m_irq = 0; m_halt = 0; m_prev = 0; m_id = 4'hF; m_phase = 0;
    endtask

    task automatic model_step();
        logic [15:0] clr, rise, en;
        bit pend;
        en = m_ie & m_if;
        pend = en != 0;
        m_irq = m_ime && pend;
        m_id = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (en[i]) begin
                m_id = 4'(i);
                break;
            end
        end
        if (m_phase != 0 && pend) m_phase = 0;
        else if (m_phase == 0 && !pend && reg_wr_en && reg_wr_idx == 2 && reg_wr_be[1] && !reg_wr_data[15]) m_phase = 1;
        else if (m_phase == 1 && cpu_ack_halt) m_phase = 2;
        m_halt = m_phase != 0;
        rise = 16'(irq_src & ~m_prev);
        clr = 0;
        if (reg_wr_en && reg_wr_idx == 0) begin
            if (reg_wr_be[2]) clr[7:0]  = reg_wr_data[23:16];
            if (reg_wr_be[3]) clr[15:8] = reg_wr_data[31:24];
            if (reg_wr_be[0]) m_ie[7:0]  = reg_wr_data[7:0];
            if (reg_wr_be[1]) m_ie[15:8] = reg_wr_data[15:8];
        end
        m_ie = m_ie & 16'h3FFF;
        m_if = ((m_if & ~clr) | rise) & 16'h3FFF;
        if (reg_wr_en && reg_wr_idx == 1 && reg_wr_be[0]) m_ime = reg_wr_data[0];
        m_prev = irq_src;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clock_16);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] src_r;
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #3;
        chk("rst_IE", 32'(IE), 0);
        chk("rst_IF", 32'(IF), 0);
        chk("rst_IME", 32'(IME), 0);
        chk("rst_irq", 32'(cpu_irq), 0);
        chk("rst_halt", 32'(cpu_halt), 0);
        do_reset();

        tbl.push_back(mk(1, 0, 32'h0000_0008, 4'b0011, 14'h0000, 0, 16'h0008, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0000_0001, 4'b0001, 14'h0000, 0, 16'h0008, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0008, 0, 16'h0008, 16'h0008, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0008, 0, 16'h0008, 16'h0008, 1, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0008_0000, 4'b1100, 14'h0008, 0, 16'h0008, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0008, 0, 16'h0008, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0000, 0, 16'h0008, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0018, 0, 16'h0008, 16'h0018, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0008, 0, 16'h0008, 16'h0018, 1, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0010_0000, 4'b1100, 14'h0018, 0, 16'h0008, 16'h0018, 1, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0018_0000, 4'b1100, 14'h0000, 0, 16'h0008, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0000, 0, 16'h0008, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_0000, 4'b0011, 14'h0040, 0, 16'h0000, 16'h0040, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0000, 0, 16'h0000, 16'h0040, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_0040, 4'b0011, 14'h0000, 0, 16'h0040, 16'h0040, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0000, 0, 16'h0040, 16'h0040, 1, 1, 0));
        tbl.push_back(mk(1, 1, 32'h0000_0000, 4'b0001, 14'h0000, 0, 16'h0040, 16'h0040, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0000, 0, 16'h0040, 16'h0040, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'hFFFF_FFFF, 4'b0000, 14'h0000, 0, 16'h0040, 16'h0040, 0, 0, 0));
        tbl.push_back(mk(1, 3, 32'hFFFF_FFFF, 4'b1111, 14'h0000, 0, 16'h0040, 16'h0040, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_FFFF, 4'b0011, 14'h0000, 0, 16'h3FFF, 16'h0040, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'hFFFF_0000, 4'b1100, 14'h0000, 0, 16'h3FFF, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 2, 32'h0000_0000, 4'b0010, 14'h0000, 0, 16'h3FFF, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0000, 1, 16'h3FFF, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h1000, 1, 16'h3FFF, 16'h1000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0000, 1, 16'h3FFF, 16'h1000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0000, 0, 16'h3FFF, 16'h1000, 0, 0, 0));
        tbl.push_back(mk(1, 2, 32'h0000_0000, 4'b0010, 14'h0000, 0, 16'h3FFF, 16'h1000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0000, 1, 16'h3FFF, 16'h1000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h1000_0000, 4'b1100, 14'h0000, 0, 16'h3FFF, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 2, 32'h0000_8000, 4'b0010, 14'h0000, 0, 16'h3FFF, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 2, 32'h0000_0000, 4'b0001, 14'h0000, 0, 16'h3FFF, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 2, 32'h0000_0000, 4'b0010, 14'h0000, 0, 16'h3FFF, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0001, 0, 16'h3FFF, 16'h0001, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 14'h0000, 1, 16'h3FFF, 16'h0001, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0000_0001, 4'b0001, 14'h0000, 0, 16'h3FFF, 16'h0001, 1, 0, 0));
        tbl.push_back(mk(1, 1, 32'hFFFF_FFFE, 4'b1111, 14'h0000, 0, 16'h3FFF, 16'h0001, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h0000_0001, 4'b1110, 14'h0000, 0, 16'h3FFF, 16'h0001, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].wr, tbl[i].idx, tbl[i].data, tbl[i].be, tbl[i].src, tbl[i].ack);
            tick();
            chk($sformatf("v%0d_IE", i), 32'(IE), 32'(tbl[i].e_ie));
            chk($sformatf("v%0d_IF", i), 32'(IF), 32'(tbl[i].e_if));
            chk($sformatf("v%0d_IME", i), 32'(IME), 32'(tbl[i].e_ime));
            chk($sformatf("v%0d_irq", i), 32'(cpu_irq), 32'(tbl[i].e_irq));
            chk($sformatf("v%0d_halt", i), 32'(cpu_halt), 32'(tbl[i].e_halt));
        end

        // reset asserted mid-cycle while halted clears everything without a clock edge
        drive(1, 0, 32'hFFFF_0000, 4'b1100, 0, 0); tick();
        drive(1, 1, 32'h0000_0001, 4'b0001, 0, 0); tick();
        drive(1, 2, 32'h0000_0000, 4'b0010, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 1); tick();
        chk("halted_before_rst", 32'(cpu_halt), 1);
        chk("ime_before_rst", 32'(IME), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_IE", 32'(IE), 0);
        chk("async_IF", 32'(IF), 0);
        chk("async_IME", 32'(IME), 0);
        chk("async_irq", 32'(cpu_irq), 0);
        chk("async_halt", 32'(cpu_halt), 0);
        do_reset();

`ifdef GBA_IRQ_PRIO_ENC_EN
        chk("prio_rst", 32'(irq_id), 32'hF);
        drive(1, 0, 32'h0000_3FFF, 4'b0011, 0, 0); tick();
        drive(0, 0, 0, 0, 14'h0220, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("prio_5", 32'(irq_id), 5);
        drive(1, 0, 32'h0020_0000, 4'b1100, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("prio_9", 32'(irq_id), 9);
        drive(1, 0, 32'hFFFF_0000, 4'b1100, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("prio_none", 32'(irq_id), 32'hF);
        do_reset();
`endif

        src_r = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) src_r = src_r ^ (N'($urandom) & N'($urandom) & N'($urandom));
            drive($urandom_range(0, 3) == 0, 2'($urandom), $urandom, 4'($urandom), src_r, 1'($urandom));
            model_step();
            tick();
            chk("rnd_IE", 32'(IE), 32'(m_ie));
            chk("rnd_IF", 32'(IF), 32'(m_if));
            chk("rnd_IME", 32'(IME), 32'(m_ime));
            chk("rnd_irq", 32'(cpu_irq), 32'(m_irq));
            chk("rnd_halt", 32'(cpu_halt), 32'(m_halt));
`ifdef GBA_IRQ_PRIO_ENC_EN
            chk("rnd_id", 32'(irq_id), 32'(m_id));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
